// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the MIPS pipeline.
// Holds the PC, a word-addressed instruction memory and the IF/ID output
// registers. Handles sequential fetch, stall, branch redirect with wrong-path
// flush, and a sticky halt when the PC about to be fetched is illegal.
//
// Ports:
//   Clk, Rst_n     - clock (rising edge), asynchronous active-low reset
//   stall          - hold PC and IF/ID outputs
//   branchTaken    - redirect fetch to branchTarget (wins over stall)
//   branchTarget   - byte address of redirect target
//   imemWe/imemWaddr/imemWdata - program-load write port (any state)
//   instruction    - fetched word to decode
//   pcOut/pcPlus4  - byte address of instruction and that address + 4
//   instValid      - instruction is real and not flushed
//   fault          - sticky illegal-PC indication
module fetch_stage #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          stall,
  input  logic                          branchTaken,
  input  logic [31:0]                   branchTarget,
  input  logic                          imemWe,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imemWaddr,
  input  logic [31:0]                   imemWdata,
  output logic [31:0]                   instruction,
  output logic [31:0]                   pcOut,
  output logic [31:0]                   pcPlus4,
  output logic                          instValid,
  output logic                          fault
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [31:0] imem_q [IMEM_DEPTH];
  logic [31:0] fetch_word;

  // Misaligned or beyond the last memory word; no wrap-around.
  function automatic logic illegal_pc(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (32'(addr[31:2]) >= 32'(IMEM_DEPTH));
  endfunction

  // Index is AW bits wide, so always in range; legality is checked separately.
  assign fetch_word = imem_q[pc_q[2+:AW]];

  // Program-load port; not reset. The fetch flop samples the old word on a
  // same-edge write, giving read-before-write.
  always_ff @(posedge Clk) begin
    if (imemWe) begin
      imem_q[imemWaddr] <= imemWdata;
    end
  end

  // State and IF/ID registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      pc_out_q   <= 32'h0;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    fault_d    = fault_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (branchTaken) begin
          // Flush the wrong-path slot; pcOut/pcPlus4 keep the last real fetch.
          instr_d = 32'h0;
          valid_d = 1'b0;
          if (illegal_pc(branchTarget)) begin
            state_d = HALT;
            fault_d = 1'b1;
          end else begin
            pc_d = branchTarget;
          end
        end else if (!stall) begin
          if (illegal_pc(pc_q)) begin
            state_d = HALT;
            fault_d = 1'b1;
            valid_d = 1'b0;
            instr_d = 32'h0;
          end else begin
            instr_d    = fetch_word;
            pc_out_d   = pc_q;
            pc_plus4_d = pc_q + 32'd4;
            valid_d    = 1'b1;
            pc_d       = pc_q + 32'd4;
          end
        end
      end
      HALT: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign instruction = instr_q;
  assign pcOut       = pc_out_q;
  assign pcPlus4     = pc_plus4_q;
  assign instValid   = valid_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. Expected IF/ID output
// tuples {instruction, pcOut, pcPlus4, instValid, fault} are queued as the
// stimulus for an edge is driven and popped for comparison after that edge.
// Instance a uses IMEM_DEPTH=256, instance b uses IMEM_DEPTH=16.
module tb_fetch_stage;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Instance a (depth 256)
  logic        rst_n_a = 1'b0, stall_a = 1'b0, br_a = 1'b0, we_a = 1'b0;
  logic [31:0] bt_a = 32'h0, wd_a = 32'h0;
  logic [7:0]  wa_a = 8'h0;
  logic [31:0] instr_a, pc_a, pc4_a;
  logic        valid_a, fault_a;

  // Instance b (depth 16)
  logic        rst_n_b = 1'b0, we_b = 1'b0;
  logic [31:0] wd_b = 32'h0;
  logic [3:0]  wa_b = 4'h0;
  logic [31:0] instr_b, pc_b, pc4_b;
  logic        valid_b, fault_b;

  fetch_stage #(.IMEM_DEPTH(256), .RESET_PC(32'h0)) dut_a (
    .Clk(Clk), .Rst_n(rst_n_a), .stall(stall_a), .branchTaken(br_a),
    .branchTarget(bt_a), .imemWe(we_a), .imemWaddr(wa_a), .imemWdata(wd_a),
    .instruction(instr_a), .pcOut(pc_a), .pcPlus4(pc4_a),
    .instValid(valid_a), .fault(fault_a)
  );

  fetch_stage #(.IMEM_DEPTH(16), .RESET_PC(32'h0)) dut_b (
    .Clk(Clk), .Rst_n(rst_n_b), .stall(1'b0), .branchTaken(1'b0),
    .branchTarget(32'h0), .imemWe(we_b), .imemWaddr(wa_b), .imemWdata(wd_b),
    .instruction(instr_b), .pcOut(pc_b), .pcPlus4(pc4_b),
    .instValid(valid_b), .fault(fault_b)
  );

  logic [97:0] obs_a, obs_b, e;
  assign obs_a = {instr_a, pc_a, pc4_a, valid_a, fault_a};
  assign obs_b = {instr_b, pc_b, pc4_b, valid_b, fault_b};

  logic [97:0] sb[$];
  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] NEW5 = 32'hDEAD_BEEF;

  function automatic logic [97:0] pk(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] pc4, input logic v, input logic f);
    return {ins, pc, pc4, v, f};
  endfunction

  // Program image of instance a.
  function automatic logic [31:0] w(input int i);
    case (i)
      0: return 32'h2008_0005;
      1: return 32'h2009_0003;
      2: return 32'h0109_5020;
      3: return 32'h0000_0000;
      default: return 32'hA500_0000 | 32'(i);
    endcase
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    for (int i = 0; i < 32; i++) begin
      we_a = 1'b1; wa_a = 8'(i); wd_a = w(i);
      if (i < 16) begin
        we_b = 1'b1; wa_b = 4'(i); wd_b = 32'h5A00_0000 | 32'(i);
      end else begin
        we_b = 1'b0;
      end
      tick();
    end
    we_a = 1'b0; we_b = 1'b0;
    sb.push_back(pk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    e = sb.pop_front(); vectors++;
    if (obs_a !== e) begin miscompares++; $display("FAIL reset_a got=%h exp=%h", obs_a, e); end
    sb.push_back(pk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    e = sb.pop_front(); vectors++;
    if (obs_b !== e) begin miscompares++; $display("FAIL reset_b got=%h exp=%h", obs_b, e); end
  endtask

  // Bubble after reset release, then words 0..2.
  task automatic test_sequential();
    rst_n_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) sb.push_back(pk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
      else        sb.push_back(pk(w(i-1), 32'(4*(i-1)), 32'(4*i), 1'b1, 1'b0));
      tick();
      e = sb.pop_front(); vectors++;
      if (obs_a !== e) begin miscompares++; $display("FAIL seq[%0d] got=%h exp=%h", i, obs_a, e); end
    end
  endtask

  task automatic test_stall();
    stall_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(pk(w(2), 32'd8, 32'd12, 1'b1, 1'b0));
      tick();
      e = sb.pop_front(); vectors++;
      if (obs_a !== e) begin miscompares++; $display("FAIL stall[%0d] got=%h exp=%h", i, obs_a, e); end
    end
    stall_a = 1'b0;
    sb.push_back(pk(w(3), 32'd12, 32'd16, 1'b1, 1'b0));
    tick();
    e = sb.pop_front(); vectors++;
    if (obs_a !== e) begin miscompares++; $display("FAIL stall_release got=%h exp=%h", obs_a, e); end
  endtask

  // Branch wins over stall on the same edge.
  task automatic test_branch();
    br_a = 1'b1; bt_a = 32'h40; stall_a = 1'b1;
    sb.push_back(pk(32'h0, 32'd12, 32'd16, 1'b0, 1'b0));
    tick();
    br_a = 1'b0; stall_a = 1'b0;
    e = sb.pop_front(); vectors++;
    if (obs_a !== e) begin miscompares++; $display("FAIL branch_flush got=%h exp=%h", obs_a, e); end
    for (int i = 0; i < 2; i++) begin
      sb.push_back(pk(w(16+i), 32'(32'h40 + 4*i), 32'(32'h44 + 4*i), 1'b1, 1'b0));
      tick();
      e = sb.pop_front(); vectors++;
      if (obs_a !== e) begin miscompares++; $display("FAIL branch_target[%0d] got=%h exp=%h", i, obs_a, e); end
    end
  endtask

  // Same-edge write and fetch of word 5 returns the old word.
  task automatic test_read_before_write();
    br_a = 1'b1; bt_a = 32'h14;
    sb.push_back(pk(32'h0, 32'h44, 32'h48, 1'b0, 1'b0));
    tick();
    e = sb.pop_front(); vectors++;
    if (obs_a !== e) begin miscompares++; $display("FAIL rbw_flush1 got=%h exp=%h", obs_a, e); end
    br_a = 1'b0; we_a = 1'b1; wa_a = 8'd5; wd_a = NEW5;
    sb.push_back(pk(w(5), 32'h14, 32'h18, 1'b1, 1'b0));
    tick();
    e = sb.pop_front(); vectors++;
    if (obs_a !== e) begin miscompares++; $display("FAIL rbw_old got=%h exp=%h", obs_a, e); end
    we_a = 1'b0; br_a = 1'b1; bt_a = 32'h14;
    sb.push_back(pk(32'h0, 32'h14, 32'h18, 1'b0, 1'b0));
    tick();
    e = sb.pop_front(); vectors++;
    if (obs_a !== e) begin miscompares++; $display("FAIL rbw_flush2 got=%h exp=%h", obs_a, e); end
    br_a = 1'b0;
    sb.push_back(pk(NEW5, 32'h14, 32'h18, 1'b1, 1'b0));
    tick();
    e = sb.pop_front(); vectors++;
    if (obs_a !== e) begin miscompares++; $display("FAIL rbw_new got=%h exp=%h", obs_a, e); end
  endtask

  // Misaligned target halts; HALT ignores inputs; async reset clears it.
  task automatic test_fault_halt();
    br_a = 1'b1; bt_a = 32'h42;
    sb.push_back(pk(32'h0, 32'h14, 32'h18, 1'b0, 1'b1));
    tick();
    e = sb.pop_front(); vectors++;
    if (obs_a !== e) begin miscompares++; $display("FAIL fault_entry got=%h exp=%h", obs_a, e); end
    for (int i = 0; i < 10; i++) begin
      stall_a = 1'($urandom_range(0, 1));
      br_a    = 1'(i % 2);
      bt_a    = 32'h8;
      sb.push_back(pk(32'h0, 32'h14, 32'h18, 1'b0, 1'b1));
      tick();
      e = sb.pop_front(); vectors++;
      if (obs_a !== e) begin miscompares++; $display("FAIL halt_frozen[%0d] got=%h exp=%h", i, obs_a, e); end
    end
    br_a = 1'b0; stall_a = 1'b0;
    #2;
    rst_n_a = 1'b0;
    sb.push_back(pk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    #1;
    e = sb.pop_front(); vectors++;
    if (obs_a !== e) begin miscompares++; $display("FAIL async_reset got=%h exp=%h", obs_a, e); end
    tick();
    // Restart: bubble, then words 0..5 (memory survives reset, word 5 rewritten).
    rst_n_a = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      sb.push_back(pk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
      else if (i == 6) sb.push_back(pk(NEW5, 32'h14, 32'h18, 1'b1, 1'b0));
      else             sb.push_back(pk(w(i-1), 32'(4*(i-1)), 32'(4*i), 1'b1, 1'b0));
      tick();
      e = sb.pop_front(); vectors++;
      if (obs_a !== e) begin miscompares++; $display("FAIL restart[%0d] got=%h exp=%h", i, obs_a, e); end
    end
  endtask

  // Depth-16 instance runs off the end of memory and faults, no wrap.
  task automatic test_no_wrap();
    rst_n_b = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i == 0) sb.push_back(pk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
      else        sb.push_back(pk(32'h5A00_0000 | 32'(i-1), 32'(4*(i-1)), 32'(4*i), 1'b1, 1'b0));
      tick();
      e = sb.pop_front(); vectors++;
      if (obs_b !== e) begin miscompares++; $display("FAIL wrap_seq[%0d] got=%h exp=%h", i, obs_b, e); end
    end
    for (int i = 0; i < 3; i++) begin
      sb.push_back(pk(32'h0, 32'h3C, 32'h40, 1'b0, 1'b1));
      tick();
      e = sb.pop_front(); vectors++;
      if (obs_b !== e) begin miscompares++; $display("FAIL wrap_fault[%0d] got=%h exp=%h", i, obs_b, e); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_read_before_write();
    test_fault_halt();
    test_no_wrap();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
